// File: rtl/slice_sched_pkg.sv
// slice_sched_pkg: shared types and default sizes for the slice read scheduler.
package slice_sched_pkg;

    localparam int NB_WORDS_DEF  = 256;
    localparam int NB_SLICES_DEF = 128;
    localparam int PIX_W         = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/slice_addr_gen.sv
// slice_addr_gen: slice RAM address counter plus the pipe that delays the
// word-valid, last-word and blank markers by the RAM read latency, so they
// line up with rdata.
module slice_addr_gen
    import slice_sched_pkg::*;
#(
    parameter int NB_WORDS   = NB_WORDS_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       run,
    input  logic       blank,
    output logic [7:0] raddr,
    output logic       addr_last,
    output logic       pix_valid,
    output logic       pix_last,
    output logic       pix_blank
);

    logic [7:0]            raddr_q, raddr_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] last_q, last_d;
    logic [RD_LATENCY-1:0] blank_q, blank_d;

    assign addr_last = run && (raddr_q == 8'(NB_WORDS - 1));

    // Address counts only while streaming and parks at 0 otherwise, so every
    // slice starts at word 0 without an explicit clear.
    always_comb begin
        raddr_d = 8'd0;
        if (run) begin
            raddr_d = addr_last ? 8'd0 : raddr_q + 8'd1;
        end
    end

    // Shift the per-address markers through RD_LATENCY stages.
    always_comb begin
        vld_d      = vld_q;
        last_d     = last_q;
        blank_d    = blank_q;
        vld_d[0]   = run;
        last_d[0]  = addr_last;
        blank_d[0] = run && blank;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            last_d[i]  = last_q[i-1];
            blank_d[i] = blank_q[i-1];
        end
    end

    // Registers; reset drops anything in flight so an aborted slice emits nothing more.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            raddr_q <= 8'd0;
            vld_q   <= '0;
            last_q  <= '0;
            blank_q <= '0;
        end else begin
            raddr_q <= raddr_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            blank_q <= blank_d;
        end
    end

    assign raddr     = raddr_q;
    assign pix_valid = vld_q[RD_LATENCY-1];
    assign pix_last  = last_q[RD_LATENCY-1];
    assign pix_blank = blank_q[RD_LATENCY-1];

endmodule

// File: rtl/slice_read_scheduler.sv
// slice_read_scheduler: turns rotation-sync slice requests into a slice FIFO
// start handshake followed by a full read of one slice from the slice RAM.
// Build option: define SLICE_SCHED_BLANK_EN to stream an all-zero slice after
// an underrun so the LED drivers keep their timing.
module slice_read_scheduler
    import slice_sched_pkg::*;
#(
    parameter int NB_WORDS   = NB_WORDS_DEF,
    parameter int NB_SLICES  = NB_SLICES_DEF,
    parameter int RETRY_MAX  = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        slice_req,
    output logic        sof_in,
    output logic [7:0]  rslice_number,
    input  logic        sof_ack,
    output logic [7:0]  raddr,
    input  logic [23:0] rdata,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_last,
    output logic        underrun,
    output logic [15:0] underrun_count,
    output logic        req_drop
);

    state_t      state_q, state_d;
    logic [7:0]  slice_q, slice_d;
    logic [7:0]  cnt_q, cnt_d;        // retry count in REQ, latency count in DRAIN
    logic        pending_q, pending_d;
    logic        underrun_q, underrun_d;
    logic [15:0] ucount_q, ucount_d;
    logic        drop_q, drop_d;
    logic        blank_q, blank_d;    // current STREAM carries a blank slice

    logic        run, addr_last, pix_blank;
    logic        have_req, timeout, drain_done, consume;
    pixel_t      pix_word;

    assign have_req   = slice_req || pending_q;
    assign timeout    = (state_q == ST_REQ) && !sof_ack && (cnt_q == 8'(RETRY_MAX - 1));
    assign drain_done = (state_q == ST_DRAIN) && (cnt_q == 8'(RD_LATENCY - 1));
    assign consume    = (state_d == ST_REQ) && (state_q != ST_REQ);

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; DRAIN goes straight to REQ when work is waiting to keep the slice gap short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (have_req) state_d = ST_REQ;
            ST_REQ: begin
                if (sof_ack) begin
                    state_d = ST_STREAM;
                end else if (timeout) begin
`ifdef SLICE_SCHED_BLANK_EN
                    state_d = ST_STREAM;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_STREAM: if (addr_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = have_req ? ST_REQ : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        sof_in = (state_q == ST_REQ);
        run    = (state_q == ST_STREAM);
    end

    // Slice number, cycle counter, pending request and status pulses.
    always_comb begin
        slice_d    = slice_q;
        cnt_d      = 8'd0;
        pending_d  = pending_q;
        drop_d     = 1'b0;
        underrun_d = timeout;
        ucount_d   = ucount_q;
        blank_d    = blank_q;

        if ((state_d == state_q) && ((state_q == ST_REQ) || (state_q == ST_DRAIN))) begin
            cnt_d = cnt_q + 8'd1;
        end

        if ((state_q == ST_REQ) && sof_ack) begin
            slice_d = (slice_q == 8'(NB_SLICES - 1)) ? 8'd0 : slice_q + 8'd1;
            blank_d = 1'b0;
        end

        if (timeout) begin
            if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
`ifdef SLICE_SCHED_BLANK_EN
            blank_d = 1'b1;
`endif
        end

        // A request arriving as one is consumed merges into it; otherwise one is held.
        if (consume) begin
            pending_d = 1'b0;
        end else if (slice_req) begin
            if (pending_q) drop_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            slice_q    <= 8'd0;
            cnt_q      <= 8'd0;
            pending_q  <= 1'b0;
            underrun_q <= 1'b0;
            ucount_q   <= 16'd0;
            drop_q     <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            slice_q    <= slice_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            ucount_q   <= ucount_d;
            drop_q     <= drop_d;
            blank_q    <= blank_d;
        end
    end

    slice_addr_gen #(
        .NB_WORDS   (NB_WORDS),
        .RD_LATENCY (RD_LATENCY)
    ) u_addr_gen (
        .clk       (clk),
        .nrst      (nrst),
        .run       (run),
        .blank     (blank_q),
        .raddr     (raddr),
        .addr_last (addr_last),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_blank (pix_blank)
    );

    assign pix_word       = (pix_valid && !pix_blank) ? rdata : '0;
    assign pix_data       = pix_word;
    assign rslice_number  = slice_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucount_q;
    assign req_drop       = drop_q;

endmodule
